// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl
//   Memory-mapped UART controller sitting between the CPU MEM stage and the
//   UART transmitter/receiver. Decodes the 0x8000_00xx I/O window, buffers
//   outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO, and returns
//   registered load data one cycle after the load so the writeback mux can
//   treat UART reads exactly like synchronous DMEM reads.
//
//   Register map (offset = cpu_addr[4:2], cpu_addr[1:0] ignored):
//     0x00 R  {30'b0, tx_ovf, tx_not_full}
//     0x04 R  {31'b0, rx_not_empty}
//     0x08 W  push cpu_wdata[7:0] into the TX FIFO
//     0x0C R  pop RX FIFO, returns {24'b0, byte} (0 and no pop when empty)
//     0x10 RW only with UART_MMIO_STATS_EN defined:
//             R {16'b0, rx_count, tx_count}, W clears tx_ovf
//
//   Optional feature macro: UART_MMIO_STATS_EN
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     cpu_addr/we/re/wdata  MEM-stage access (we and re together: write wins)
//     cpu_hit               combinational address decode hit
//     cpu_rdata             registered load data
//     tx_data/valid/ready   byte stream to the UART transmitter
//     rx_data/valid/ready   byte stream from the UART receiver

module uart_mmio_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_hit,
  output logic [31:0] cpu_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);

  localparam logic [2:0] OFF_TX_STATUS = 3'd0;
  localparam logic [2:0] OFF_RX_STATUS = 3'd1;
  localparam logic [2:0] OFF_TX_DATA   = 3'd2;
  localparam logic [2:0] OFF_RX_DATA   = 3'd3;
  localparam logic [2:0] OFF_STATS     = 3'd4;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_CW-1:0] tx_count;
  logic             tx_ovf;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_CW-1:0] rx_count;

  logic        window_ok;
  logic [2:0]  offset;
  logic        offset_mapped;
  logic        rd_req;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push_req, tx_push, tx_drop, tx_pop;
  logic        rx_push, rx_pop;
  logic        stats_clear;
  logic [31:0] read_value;
  logic        unused_bits;

  assign unused_bits = ^{cpu_addr[1:0], cpu_wdata[31:8]};

  // Address decode: the I/O window is 0x8000_0000..0x8000_001F.
  assign window_ok = (cpu_addr[31:28] == 4'h8) && (cpu_addr[27:5] == '0);
  assign offset    = cpu_addr[4:2];

  always_comb begin
    offset_mapped = 1'b0;
    case (offset)
      OFF_TX_STATUS, OFF_RX_STATUS, OFF_TX_DATA, OFF_RX_DATA: offset_mapped = 1'b1;
`ifdef UART_MMIO_STATS_EN
      OFF_STATS: offset_mapped = 1'b1;
`endif
      default: offset_mapped = 1'b0;
    endcase
  end

  assign cpu_hit = window_ok && offset_mapped;

  // A simultaneous store and load is illegal; the load is simply ignored.
  assign rd_req = cpu_re && !cpu_we;

  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign rx_empty = (rx_count == '0);

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd_ptr];
  // rx_ready must be low during reset even though the count already reads 0.
  assign rx_ready = rst_n && !rx_full;

  // Full is judged before this cycle's pop, so a store to a full FIFO drops
  // even when the transmitter drains an entry on the same edge.
  assign tx_push_req = cpu_we && cpu_hit && (offset == OFF_TX_DATA);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_drop     = tx_push_req && tx_full;
  assign tx_pop      = tx_valid && tx_ready;

  assign rx_push = rx_valid && rx_ready;
  assign rx_pop  = rd_req && cpu_hit && (offset == OFF_RX_DATA) && !rx_empty;

`ifdef UART_MMIO_STATS_EN
  assign stats_clear = cpu_we && cpu_hit && (offset == OFF_STATS);
`else
  assign stats_clear = 1'b0;
`endif

  // Load data mux, sampled from pre-edge state.
  always_comb begin
    read_value = '0;
    if (cpu_hit) begin
      case (offset)
        OFF_TX_STATUS: read_value = {30'b0, tx_ovf, !tx_full};
        OFF_RX_STATUS: read_value = {31'b0, !rx_empty};
        OFF_RX_DATA:   if (!rx_empty) read_value = {24'b0, rx_mem[rx_rd_ptr]};
`ifdef UART_MMIO_STATS_EN
        OFF_STATS:     read_value = {16'b0, 8'(rx_count), 8'(tx_count)};
`endif
        default:       read_value = '0;
      endcase
    end
  end

  // FIFO storage needs no reset; the pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= cpu_wdata[7:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      tx_ovf    <= 1'b0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      cpu_rdata <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase

      // A dropped write takes priority over a stats clear.
      if (tx_drop)          tx_ovf <= 1'b1;
      else if (stats_clear) tx_ovf <= 1'b0;

      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase

      if (rd_req) cpu_rdata <= read_value;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl
//   Self-checking bench for uart_mmio_ctrl. Directed scenarios followed by a
//   randomized phase, all compared against a queue-based behavioural model.

module tb_uart_mmio_ctrl;

  localparam int TXD = 4;
  localparam int RXD = 4;
`ifdef UART_MMIO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic        cpu_we, cpu_re;
  logic [31:0] cpu_wdata;
  logic        cpu_hit;
  logic [31:0] cpu_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;

  int checks = 0;
  int failures = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic        m_ovf;
  logic [31:0] m_rdata;

  uart_mmio_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_wdata(cpu_wdata),
    .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    int off;
    off = int'(a[4:2]);
    if (a[31:28] != 4'h8 || a[27:5] != 23'd0) return 1'b0;
    return (off <= 3) || (STATS && off == 4);
  endfunction

  // Reference behaviour of one clock edge given the currently driven inputs.
  task automatic modelEdge();
    int  off;
    bit  hit, rd, full, push_req, pop, rxpop, rxpush;
    off = int'(cpu_addr[4:2]);
    hit = m_hit(cpu_addr);
    rd  = cpu_re && !cpu_we;
    if (rd) begin
      m_rdata = 32'd0;
      if (hit) begin
        if (off == 0)      m_rdata = (m_ovf ? 32'd2 : 32'd0) + ((tx_q.size() < TXD) ? 32'd1 : 32'd0);
        else if (off == 1) m_rdata = (rx_q.size() > 0) ? 32'd1 : 32'd0;
        else if (off == 3) m_rdata = (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'd0;
        else if (off == 4) m_rdata = 32'(rx_q.size() * 256 + tx_q.size());
      end
    end
    full     = (tx_q.size() == TXD);
    push_req = cpu_we && hit && off == 2;
    pop      = (tx_q.size() > 0) && tx_ready;
    if (push_req && full) m_ovf = 1'b1;
    else if (STATS && cpu_we && hit && off == 4) m_ovf = 1'b0;
    rxpop  = rd && hit && off == 3 && rx_q.size() > 0;
    rxpush = rx_valid && (rx_q.size() < RXD);
    if (pop) void'(tx_q.pop_front());
    if (push_req && !full) tx_q.push_back(cpu_wdata[7:0]);
    if (rxpop) void'(rx_q.pop_front());
    if (rxpush) rx_q.push_back(rx_data);
  endtask

  // Drive one cycle of inputs, check combinational outputs, clock, check rdata.
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic re,
                               input logic [7:0] wd, input logic txr,
                               input logic rxv, input logic [7:0] rxd);
    cpu_addr  = addr;
    cpu_we    = we;
    cpu_re    = re;
    cpu_wdata = {$urandom_range(0, 255), $urandom_range(0, 65535), wd};
    tx_ready  = txr;
    rx_valid  = rxv;
    rx_data   = rxd;
    #1;
    checkOutput("cpu_hit", 32'(cpu_hit), 32'(m_hit(addr)));
    checkOutput("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
    if (tx_q.size() != 0) checkOutput("tx_data", 32'(tx_data), 32'(tx_q[0]));
    checkOutput("rx_ready", 32'(rx_ready), 32'(rx_q.size() < RXD));
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput("cpu_rdata", cpu_rdata, m_rdata);
  endtask

  task automatic modelReset();
    tx_q.delete();
    rx_q.delete();
    m_ovf   = 1'b0;
    m_rdata = 32'd0;
  endtask

  task automatic idle(input logic txr, input logic rxv, input logic [7:0] rxd);
    applyStimulus(32'h0, 1'b0, 1'b0, 8'h00, txr, rxv, rxd);
  endtask

  logic [31:0] addr_tab [10];
  logic [7:0]  first_rx;

  initial begin
    addr_tab = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C,
                 32'h8000_0010, 32'h8000_0014, 32'h8000_001C, 32'h8000_0020,
                 32'h0000_0008, 32'h9000_000C};
    rst_n = 1'b0; cpu_addr = '0; cpu_we = 0; cpu_re = 0; cpu_wdata = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    modelReset();

    // Reset state
    #12;
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_rx_ready_low", 32'(rx_ready), 32'd0);
    checkOutput("rst_rdata", cpu_rdata, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_rx_ready", 32'(rx_ready), 32'd1);
    applyStimulus(32'h8000_0000, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("status0_after_reset", cpu_rdata, 32'h1);
    applyStimulus(32'h8000_0004, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("status4_after_reset", cpu_rdata, 32'h0);

    // TX fill with overflow, then drain
    for (int i = 0; i < 5; i++) applyStimulus(32'h8000_0008, 1, 0, 8'(8'h41 + i), 0, 0, 8'h00);
    applyStimulus(32'h8000_0000, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("tx_full_ovf_status", cpu_rdata, 32'h2);
    checkOutput("tx_head_first", 32'(tx_data), 32'h41);
    for (int i = 0; i < 4; i++) begin
      idle(1, 0, 8'h00);
      if (i < 3) checkOutput("tx_seq", 32'(tx_data), 32'(8'h42 + i));
    end
    checkOutput("tx_drained", 32'(tx_valid), 32'd0);

    // RX basic receive and pops, including pop-while-empty
    idle(0, 1, 8'h10);
    idle(0, 1, 8'h20);
    applyStimulus(32'h8000_0004, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("rx_not_empty", cpu_rdata, 32'h1);
    applyStimulus(32'h8000_000C, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("rx_pop1", cpu_rdata, 32'h10);
    applyStimulus(32'h8000_000E, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("rx_pop2", cpu_rdata, 32'h20);
    applyStimulus(32'h8000_000C, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("rx_pop_empty", cpu_rdata, 32'h0);
    applyStimulus(32'h8000_0004, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("rx_still_empty", cpu_rdata, 32'h0);

    // RX full with held rx_valid, read frees a slot
    first_rx = 8'($urandom_range(0, 255));
    idle(0, 1, first_rx);
    for (int i = 0; i < 3; i++) idle(0, 1, 8'($urandom_range(0, 255)));
    checkOutput("rx_full_ready", 32'(rx_ready), 32'd0);
    applyStimulus(32'h8000_000C, 0, 1, 8'h00, 0, 1, 8'h55);
    checkOutput("rx_full_pop", cpu_rdata, 32'(first_rx));
    checkOutput("rx_ready_after_pop", 32'(rx_ready), 32'd1);
    idle(0, 1, 8'h55);
    checkOutput("rx_held_accepted", 32'(rx_ready), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(32'h8000_000C, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("rx_held_byte", cpu_rdata, 32'h55);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) applyStimulus(32'h8000_0008, 1, 0, 8'(8'hA0 + i), 0, 0, 8'h00);
    applyStimulus(32'h8000_0000, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("pre_reset_rdata", cpu_rdata, 32'h3);
    #3 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("async_rst_rdata", cpu_rdata, 32'd0);
    checkOutput("async_rst_rx_ready", 32'(rx_ready), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h8000_0000, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("status_after_async_rst", cpu_rdata, 32'h1);

    // Stats register
`ifdef UART_MMIO_STATS_EN
    for (int i = 0; i < 2; i++) applyStimulus(32'h8000_0008, 1, 0, 8'(i), 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) idle(0, 1, 8'(i));
    applyStimulus(32'h8000_0010, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("stats_counts", cpu_rdata, 32'h0000_0302);
    for (int i = 0; i < 3; i++) applyStimulus(32'h8000_0008, 1, 0, 8'(i), 0, 0, 8'h00);
    applyStimulus(32'h8000_0000, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("stats_ovf_set", cpu_rdata, 32'h2);
    applyStimulus(32'h8000_0010, 1, 0, 8'h00, 0, 0, 8'h00);
    applyStimulus(32'h8000_0000, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("stats_ovf_cleared", cpu_rdata, 32'h0);
`else
    applyStimulus(32'h8000_0000, 0, 1, 8'h00, 0, 0, 8'h00);
    applyStimulus(32'h8000_0010, 0, 1, 8'h00, 0, 0, 8'h00);
    checkOutput("unmapped_0x10_read", cpu_rdata, 32'h0);
    checkOutput("unmapped_0x10_hit", 32'(cpu_hit), 32'd0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] a;
      logic we, re;
      op = int'($urandom_range(0, 9));
      a  = addr_tab[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
      we = (op <= 2) || (op == 7);
      re = (op >= 3 && op <= 7);
      applyStimulus(a, we, re, 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
                    8'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
